stoch_neuron_fsm: RTL

- Parametrised successor to the stochastic NN node.
- Combines N unipolar input bitstreams with N weight-magnitude bitstreams and static per-input signs. Adds a signed bias stream.
- Feeds the per-cycle signed net count into a saturating up/down state counter, which acts as the stochastic tanh/step activation.
- Emits one registered activation bitstream per clock. Sits between layer input buses and the next layer's inputs.

---
 rtl/stoch_neuron_fsm.sv | 119 +++++++++++
 1 files changed

// File: rtl/stoch_neuron_fsm.sv
// Stochastic neuron: signed synaptic bitstream count feeding a saturating up/down
// activation counter. Optional refractory gating when STOCH_NEURON_REFRACT_EN is defined.
module stoch_neuron_fsm #(
  parameter int N       = 3,
  parameter int STATES  = 16,
  parameter int REFRACT = 2
) (
  input  logic                      CLK,
  input  logic                      INIT,
  input  logic                      EN,
  input  logic [N-1:0]              a,
  input  logic [N-1:0]              alpha,
  input  logic [N-1:0]              w_sign,
  input  logic                      beta,
  input  logic                      beta_sign,
  output logic                      z,
  output logic                      a_out,
  output logic [$clog2(STATES)-1:0] state
);

  localparam int SW   = $clog2(STATES);
  localparam int NW   = $clog2(N + 2) + 1;
  localparam int SUMW = SW + NW + 1;

  // Elaboration-time parameter sanity checks.
  if (N < 1) begin : g_chk_n
    $error("stoch_neuron_fsm: N must be >= 1");
  end
  if (STATES < 4 || (STATES & (STATES - 1)) != 0) begin : g_chk_states
    $error("stoch_neuron_fsm: STATES must be a power of 2, >= 4");
  end
  if (REFRACT < 1 || REFRACT > 255) begin : g_chk_refract
    $error("stoch_neuron_fsm: REFRACT must be in 1..255");
  end

  logic [N-1:0]           p_exc;
  logic [N-1:0]           p_inh;
  logic [NW-1:0]          pos_cnt;
  logic [NW-1:0]          neg_cnt;
  logic signed [NW-1:0]   net;
  logic signed [SUMW-1:0] sum;
  logic [SW-1:0]          state_reg;
  logic [SW-1:0]          state_next;
  logic                   a_out_reg;
  logic                   a_out_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prod
      assign p_exc[gi] = a[gi] & alpha[gi] & ~w_sign[gi];
      assign p_inh[gi] = a[gi] & alpha[gi] &  w_sign[gi];
    end
  endgenerate

  // Counts never exceed N+1, so the unsigned NW-bit accumulators cannot wrap.
  always_comb begin
    pos_cnt = NW'(beta & ~beta_sign);
    neg_cnt = NW'(beta &  beta_sign);
    for (int i = 0; i < N; i++) begin
      pos_cnt = pos_cnt + NW'(p_exc[i]);
      neg_cnt = neg_cnt + NW'(p_inh[i]);
    end
  end

  assign net = $signed(pos_cnt - neg_cnt);
  assign z   = ~net[NW-1] && (net != '0);

  assign sum = $signed({{(NW + 1){1'b0}}, state_reg}) + $signed({{(SW + 1){net[NW-1]}}, net});

  always_comb begin
    state_next = sum[SW-1:0];
    if (sum[SUMW-1]) begin
      state_next = '0;
    end else if (sum > $signed(SUMW'(STATES - 1))) begin
      state_next = SW'(STATES - 1);
    end
  end

`ifdef STOCH_NEURON_REFRACT_EN
  logic [7:0] rc_reg;
  logic [7:0] rc_next;

  // An emitted 1 arms the counter; while armed the output is forced low.
  always_comb begin
    a_out_next = state_next[SW-1];
    rc_next    = rc_reg;
    if (rc_reg != 8'd0) begin
      a_out_next = 1'b0;
      rc_next    = rc_reg - 8'd1;
    end else if (state_next[SW-1]) begin
      rc_next = 8'(REFRACT);
    end
  end

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      rc_reg <= 8'd0;
    end else if (EN) begin
      rc_reg <= rc_next;
    end
  end
`else
  assign a_out_next = state_next[SW-1];
`endif

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_reg <= SW'(STATES / 2);
      a_out_reg <= 1'b0;
    end else if (EN) begin
      state_reg <= state_next;
      a_out_reg <= a_out_next;
    end
  end

  assign state = state_reg;
  assign a_out = a_out_reg;

endmodule
